// File: rtl/tm_program_driver.sv
// tm_program_driver: replays a buffered program into the Turing machine via Next/Done pulses,
// then steps the run and emits one trace word per step until Compute_done or the step limit.
module tm_program_driver #(
    parameter int SYM_W     = 4,
    parameter int PROG_LEN  = 64,
    parameter int SETUP     = 3,
    parameter int HOLD      = 2,
    parameter int GAP       = 2,
    parameter int SETTLE    = 5,
    parameter int MAX_STEPS = 32,
    localparam int ADDR_W   = $clog2(PROG_LEN)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [SYM_W-1:0]  prog_wdata,
    input  logic [ADDR_W:0]   prog_count,
    input  logic              start,
    output logic [SYM_W-1:0]  input_data,
    output logic              Next,
    output logic              Done,
    input  logic [10:0]       display,
    input  logic              Compute_done,
    output logic              busy,
    output logic              trace_valid,
    output logic [10:0]       trace_data,
    output logic [ADDR_W:0]   step_count,
    output logic              finished,
    output logic              timeout
);
    localparam int CW = ADDR_W + 1;
    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] L_SETUP  = 4'd1;
    localparam logic [3:0] L_PULSE  = 4'd2;
    localparam logic [3:0] L_GAP    = 4'd3;
    localparam logic [3:0] D_PULSE  = 4'd4;
    localparam logic [3:0] D_GAP    = 4'd5;
    localparam logic [3:0] R_SETTLE = 4'd6;
    localparam logic [3:0] R_SAMPLE = 4'd7;
    localparam logic [3:0] R_PULSE  = 4'd8;
    localparam logic [3:0] R_GAP    = 4'd9;
    localparam logic [3:0] FINISH   = 4'd10;
    localparam logic [7:0] T_SETUP  = 8'(SETUP - 1);
    localparam logic [7:0] T_HOLD   = 8'(HOLD - 1);
    localparam logic [7:0] T_GAP    = 8'(GAP - 1);
    localparam logic [7:0] T_SETTLE = 8'(SETTLE - 1);
    localparam logic [ADDR_W:0] LEN = CW'(PROG_LEN);

    logic [3:0]       state_q, state_d;
    logic [7:0]       tmr_q, tmr_d;
    logic [ADDR_W:0]  cnt_q, cnt_d, idx_q, idx_d, step_q, step_d;
    logic [ADDR_W:0]  cnt_in, idx_inc;
    logic [SYM_W-1:0] din_q, din_d;
    logic             tout_q, tout_d;
    logic [10:0]      trace_q, trace_d;
    logic [SYM_W-1:0] buf_q [PROG_LEN];
    logic             expire;

    assign cnt_in  = prog_count > LEN ? LEN : prog_count;
    assign idx_inc = idx_q + CW'(1);
    assign expire  = tmr_q == 8'd0;

    // Every timed state reloads tmr on entry and leaves when it reaches zero.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q - 8'd1;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        step_d  = step_q;
        din_d   = din_q;
        tout_d  = tout_q;
        trace_d = trace_q;
        case (state_q)
            IDLE, FINISH: if (start) begin
                cnt_d   = cnt_in;
                idx_d   = '0;
                step_d  = '0;
                tout_d  = 1'b0;
                state_d = cnt_in == '0 ? D_PULSE : L_SETUP;
                tmr_d   = cnt_in == '0 ? T_HOLD : T_SETUP;
                din_d   = cnt_in == '0 ? '0 : buf_q[0];
            end
            L_SETUP: if (expire) begin
                state_d = L_PULSE;
                tmr_d   = T_HOLD;
            end
            L_PULSE: if (expire) begin
                state_d = L_GAP;
                tmr_d   = T_GAP;
            end
            L_GAP: if (expire) begin
                idx_d   = idx_inc;
                state_d = idx_inc == cnt_q ? D_PULSE : L_SETUP;
                tmr_d   = idx_inc == cnt_q ? T_HOLD : T_SETUP;
                din_d   = idx_inc == cnt_q ? din_q : buf_q[idx_inc[ADDR_W-1:0]];
            end
            D_PULSE: if (expire) begin
                state_d = D_GAP;
                tmr_d   = T_GAP;
            end
            D_GAP, R_GAP: if (expire) begin
                state_d = R_SETTLE;
                tmr_d   = T_SETTLE;
            end
            R_SETTLE: if (expire) state_d = R_SAMPLE;
            R_SAMPLE: begin
                trace_d = display;
                if (Compute_done || step_q == CW'(MAX_STEPS)) begin
                    state_d = FINISH;
                    tout_d  = !Compute_done;
                end else begin
                    state_d = R_PULSE;
                    tmr_d   = T_HOLD;
                    step_d  = step_q + CW'(1);
                end
            end
            R_PULSE: if (expire) begin
                state_d = R_GAP;
                tmr_d   = T_GAP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            step_q  <= '0;
            din_q   <= '0;
            tout_q  <= 1'b0;
            trace_q <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            din_q   <= din_d;
            tout_q  <= tout_d;
            trace_q <= trace_d;
        end
    end

    // The buffer survives reset so a program can be replayed after an abort.
    always_ff @(posedge clock) begin
        if (prog_we && state_q == IDLE) buf_q[prog_addr] <= prog_wdata;
    end

    assign input_data  = din_q;
    assign Next        = state_q == L_PULSE || state_q == R_PULSE;
    assign Done        = state_q == D_PULSE;
    assign busy        = state_q != IDLE && state_q != FINISH;
    assign trace_valid = state_q == R_SAMPLE;
    assign trace_data  = trace_valid ? display : trace_q;
    assign step_count  = step_q;
    assign finished    = state_q == FINISH;
    assign timeout     = tout_q;
endmodule

// File: tb/tb_tm_program_driver.sv
// tb_tm_program_driver: directed checks of replay timing, run-phase tracing, reset abort and busy-time events.
module tb_tm_program_driver;
    logic        clock = 1'b0, reset = 1'b0, prog_we = 1'b0, start = 1'b0;
    logic [5:0]  prog_addr = '0;
    logic [3:0]  prog_wdata = '0;
    logic [6:0]  prog_count = '0;
    logic [3:0]  input_data;
    logic        Next, Done, busy, trace_valid, finished, timeout, Compute_done;
    logic [10:0] display, trace_data;
    logic [6:0]  step_count;
    int          nvec = 0, nmis = 0;
    int          steps = 0, halt_at = 99;
    logic        loaded = 1'b0, pn_m = 1'b0;
    int          nrise[$], nlen[$];
    int          drise, dlen, tfirst, tcount, overlap, last_busy;
    int          din_log [64];

    tm_program_driver dut (
        .clock(clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .prog_count(prog_count), .start(start),
        .input_data(input_data), .Next(Next), .Done(Done), .display(display),
        .Compute_done(Compute_done), .busy(busy), .trace_valid(trace_valid),
        .trace_data(trace_data), .step_count(step_count), .finished(finished), .timeout(timeout)
    );

    always #5 clock = ~clock;

    // Turing machine stand-in: counts run-phase Next presses after Done, halts at halt_at steps.
    assign display      = {steps[4:0], 1'b1, ~steps[4:0]};
    assign Compute_done = steps >= halt_at;

    always @(posedge clock) begin
        if (!reset || (start && !busy)) begin
            loaded <= 1'b0;
            steps  <= 0;
            pn_m   <= 1'b0;
        end else begin
            if (Done) loaded <= 1'b1;
            if (loaded && Next && !pn_m) steps <= steps + 1;
            pn_m <= Next;
        end
    end

    function automatic int tw(input int k);
        logic [4:0] s;
        s = k[4:0];
        return {21'd0, s, 1'b1, ~s};
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic write_sym(input int a, input int d);
        @(negedge clock);
        prog_we    = 1'b1;
        prog_addr  = a[5:0];
        prog_wdata = d[3:0];
        @(negedge clock);
        prog_we = 1'b0;
    endtask

    // Cycle 0 is the cycle start is high; c counts cycles after that edge.
    task automatic run(input int pc, input int limit, input int poke_c);
        int   plen = 0;
        logic pn = 1'b0, pd = 1'b0, fin = 1'b0;
        nrise.delete();
        nlen.delete();
        drise = -1; dlen = 0; tfirst = -1; tcount = 0; overlap = 0; last_busy = 0;
        for (int i = 0; i < 64; i++) din_log[i] = -1;
        @(negedge clock);
        prog_count = pc[6:0];
        start      = 1'b1;
        for (int c = 1; c <= limit && !fin; c++) begin
            @(negedge clock);
            start      = c == poke_c;
            prog_we    = c == poke_c;
            prog_addr  = 6'd1;
            prog_wdata = 4'd7;
            if (Next && Done) overlap++;
            if (Next && !pn) nrise.push_back(c);
            plen = Next ? plen + 1 : plen;
            if (!Next && pn) begin
                nlen.push_back(plen);
                plen = 0;
            end
            if (Done && !pd && drise < 0) drise = c;
            if (Done) dlen++;
            if (c < 64) din_log[c] = int'(input_data);
            if (trace_valid) begin
                if (tfirst < 0) tfirst = c;
                check("trace_word", int'(trace_data), tw(tcount));
                tcount++;
                last_busy = int'(busy);
            end
            fin = finished;
            pn  = Next;
            pd  = Done;
        end
        start   = 1'b0;
        prog_we = 1'b0;
        if (!fin) check("finish_bound", 0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_input_data", int'(input_data), 0);
        check("rst_next", int'(Next), 0);
        check("rst_done", int'(Done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_trace_valid", int'(trace_valid), 0);
        check("rst_trace_data", int'(trace_data), 0);
        check("rst_step_count", int'(step_count), 0);
        check("rst_finished", int'(finished), 0);
        check("rst_timeout", int'(timeout), 0);
        reset = 1'b1;
        write_sym(0, 3);
        write_sym(1, 1);
        write_sym(2, 0);

        halt_at = 4;
        run(3, 200, -1);
        check("t1_din_c1", din_log[1], 3);
        check("t1_din_c5", din_log[5], 3);
        check("t1_din_c8", din_log[8], 1);
        check("t1_din_c15", din_log[15], 0);
        check("t1_next_rise0", nrise[0], 4);
        check("t1_next_rise1", nrise[1], 11);
        check("t1_next_rise2", nrise[2], 18);
        check("t1_next_len0", nlen[0], 2);
        check("t1_next_len1", nlen[1], 2);
        check("t1_next_len2", nlen[2], 2);
        check("t1_next_pulses", nrise.size(), 7);
        check("t1_done_rise", drise, 22);
        check("t1_done_len", dlen, 2);
        check("t1_trace_first", tfirst, 31);
        check("t1_trace_words", tcount, 5);
        check("t1_step_count", int'(step_count), 4);
        check("t1_finished", int'(finished), 1);
        check("t1_timeout", int'(timeout), 0);
        check("t1_busy", int'(busy), 0);
        check("t1_overlap", overlap, 0);
        check("t1_trace_hold", int'(trace_data), tw(4));

        halt_at = 99;
        run(3, 600, -1);
        check("t2_din_c1", din_log[1], 3);
        check("t2_trace_words", tcount, 33);
        check("t2_step_count", int'(step_count), 32);
        check("t2_timeout", int'(timeout), 1);
        check("t2_finished", int'(finished), 1);
        check("t2_busy_end", int'(busy), 0);
        check("t2_busy_last_sample", last_busy, 1);
        check("t2_next_pulses", nrise.size(), 35);

        halt_at = 0;
        run(0, 100, -1);
        check("t3_next_pulses", nrise.size(), 0);
        check("t3_done_rise", drise, 1);
        check("t3_din_c1", din_log[1], 0);
        check("t3_trace_first", tfirst, 10);
        check("t3_trace_words", tcount, 1);
        check("t3_step_count", int'(step_count), 0);
        check("t3_timeout", int'(timeout), 0);

        halt_at = 99;
        @(negedge clock);
        prog_count = 7'd3;
        start      = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        check("t4_pre_reset_next", int'(Next), 1);
        reset = 1'b0;
        @(negedge clock);
        check("t4_rst_next", int'(Next), 0);
        check("t4_rst_busy", int'(busy), 0);
        check("t4_rst_din", int'(input_data), 0);
        reset   = 1'b1;
        halt_at = 1;
        run(3, 200, -1);
        check("t4_din_c1", din_log[1], 3);
        check("t4_din_c8", din_log[8], 1);
        check("t4_din_c15", din_log[15], 0);
        check("t4_next_rise0", nrise[0], 4);
        check("t4_trace_words", tcount, 2);

        run(3, 200, 10);
        check("t5_next_rise0", nrise[0], 4);
        check("t5_next_rise1", nrise[1], 11);
        check("t5_next_rise2", nrise[2], 18);
        check("t5_done_rise", drise, 22);
        check("t5_trace_first", tfirst, 31);
        check("t5_trace_words", tcount, 2);
        run(3, 200, -1);
        check("t5_buffer_intact", din_log[8], 1);
        check("t5_replay_c1", din_log[1], 3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/tm_program_driver.md
Name: tm_program_driver

Overview:
- Transmit-side driver for the Turing machine's button-style entry protocol (`input_data`/`Next`/`Done`, observed back via `display`/`Compute_done`).
- It replaces the human operator:
  - buffers a program of symbols written by a host;
  - replays each symbol with correctly timed `Next` pulses, then a `Done` pulse;
  - steps the computation with `Next` pulses, emitting one 11-bit trace word per step until `Compute_done` or a step limit.
- Sits between a host/scan interface and the TuringMachine instance.

Parameters:
- SYM_W, 4, width of input_data symbols
- PROG_LEN, 64, program buffer depth (power of 2); ADDR_W = clog2(PROG_LEN)
- SETUP, 3, cycles input_data is held stable before Next rises
- HOLD, 2, cycles Next/Done are held high per pulse
- GAP, 2, cycles Next/Done are held low after each pulse
- SETTLE, 5, cycles after a run-phase Next falls before display is sampled
- MAX_STEPS, 32, run-phase step limit

Ports:
- clock  input  1  single clock; all state changes on rising edge
- reset  input  1  synchronous, active-low (0 = reset), sampled on rising edge of clock
- prog_we  input  1  write program symbol (honoured only in IDLE)
- prog_addr  input  ADDR_W  write address
- prog_wdata  input  SYM_W  symbol to write
- prog_count  input  ADDR_W+1  number of symbols to replay (0..PROG_LEN), sampled on start
- start  input  1  begin replay (honoured only in IDLE or FINISH)
- input_data  output  SYM_W  symbol to TM
- Next  output  1  TM Next button
- Done  output  1  TM Done button
- display  input  11  TM tape window {left5, head, right5}
- Compute_done  input  1  TM halt flag
- busy  output  1  high from start acceptance until FINISH
- trace_valid  output  1  one-cycle strobe: trace_data valid
- trace_data  output  11  sampled display
- step_count  output  ADDR_W+1  run-phase Next pulses issued
- finished  output  1  high in FINISH
- timeout  output  1  high in FINISH if the step limit ended the run

Behaviour:
- Reset (reset==0 at an edge): state=IDLE. Every output is 0 from the next cycle: input_data, Next, Done, busy, trace_valid, trace_data, step_count, finished, timeout. Buffer contents are not cleared. Reset mid-pulse drops Next/Done immediately at that edge.
- IDLE:
  - prog_we writes buf[prog_addr]. Writes in other states are ignored.
  - start: latch cnt=min(prog_count, PROG_LEN), idx=0, step_count=0, busy=1.
  - If cnt==0 go to DONE_PULSE, else go to L_SETUP.
- L_SETUP:
  - input_data=buf[idx], driven from the first L_SETUP cycle.
  - SETUP cycles, then L_PULSE.
- L_PULSE: Next=1 for HOLD cycles; input_data unchanged.
- L_GAP:
  - Next=0 for GAP cycles.
  - Then idx++. If idx==cnt go to DONE_PULSE, else go to L_SETUP.
  - One symbol costs SETUP+HOLD+GAP = 7 cycles.
- DONE_PULSE / DONE_GAP:
  - Done=1 for HOLD cycles, then Done=0 for GAP cycles.
  - input_data is held at its last value (0 if cnt==0).
- R_SETTLE: wait SETTLE cycles.
- R_SAMPLE (1 cycle):
  - trace_valid=1, trace_data=display.
  - If Compute_done: go to FINISH, timeout=0.
  - Else if step_count==MAX_STEPS: go to FINISH, timeout=1.
  - Else go to R_PULSE.
- R_PULSE: Next=1 for HOLD cycles. step_count increments on the first R_PULSE cycle.
- R_GAP: Next=0 for GAP cycles, then R_SETTLE.
- FINISH:
  - busy=0, finished=1.
  - trace_data holds the last sample.
  - start re-enters the flow (finished/timeout clear) and reuses the buffer.
- Next and Done are never high in the same cycle.
- Pulse counters saturate-free: each is a down-counter reloaded on state entry.
- start while busy: ignored.
- start and prog_we in the same IDLE cycle: the write completes and start takes the pre-write buffer. The written symbol is used only if its address ≥ the replay index when read.
- Compute_done is only sampled in R_SAMPLE. It is ignored during load.
- A run with Compute_done already high gives exactly 1 trace word, step_count=0.

Test Plan:
- Load {3,1,0}, prog_count=3, start at cycle 0:
  - input_data=3 from cycle 1.
  - Next high cycles 4–5; input_data=1 from cycle 8.
  - Three Next pulses of exactly 2 cycles each.
  - Done high cycles 22–23.
  - First trace_valid at cycle 31.
- Drive display from a model:
  - Compute_done rises after the 4th run step.
  - Expect 5 trace words, step_count=4, finished=1, timeout=0.
- Compute_done never asserted, MAX_STEPS=32:
  - 33 trace words, step_count=32, timeout=1, busy falls after the last sample.
- prog_count=0: no load Next pulses; Done is the first pulse, rising at cycle 1.
- Reset driven low during an L_PULSE:
  - Next=0 and busy=0 at the next edge.
  - A subsequent start replays the intact buffer from index 0.
- Events issued while busy:
  - start: no effect on the sequence.
  - prog_we: no effect on buffer contents, checked by replaying after FINISH.
